// File: rtl/pc_ifid_stage_pkg.sv
// Shared front-end definitions: PCSrc encodings, hazard cause bit indices and the IF/ID payload.
package pc_ifid_stage_pkg;

  typedef enum logic [2:0] {
    PCSRC_SEQ   = 3'b000,
    PCSRC_BR    = 3'b001,
    PCSRC_J     = 3'b010,
    PCSRC_JR    = 3'b011,
    PCSRC_ILLOP = 3'b100,
    PCSRC_XADR  = 3'b101
  } pcsrc_e;

  localparam int unsigned HZ_LOADUSE = 0;
  localparam int unsigned HZ_JUMP    = 1;
  localparam int unsigned HZ_BRANCH  = 2;

  localparam int unsigned CNT_W      = 16;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } ifid_t;

  // Bit 31 is the kernel flag; only bits 30:0 take part in the increment.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/pc_ifid_stage_if.sv
// Bundle of the fetch-stage inputs from fetch/ID/EX/hazard logic and the registered stage outputs.
interface pc_ifid_stage_if import pc_ifid_stage_pkg::*; ();

  logic [31:0]      IF_Instruction;
  logic [2:0]       ID_PCSrc;
  logic [2:0]       ID_EX_PCSrc;
  logic             EX_ALUResult0;
  logic [31:0]      EX_BranchTarget;
  logic [31:0]      ID_JumpTarget;
  logic [31:0]      ID_JrTarget;
  logic [2:0]       PCWrite;
  logic [2:0]       IF_ID_WRITE;
  logic [2:0]       IF_ID_Flush;
  logic [31:0]      PC;
  logic [31:0]      IF_ID_Instruction;
  logic [31:0]      IF_ID_PC_Plus4;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output IF_Instruction, ID_PCSrc, ID_EX_PCSrc, EX_ALUResult0, EX_BranchTarget,
           ID_JumpTarget, ID_JrTarget, PCWrite, IF_ID_WRITE, IF_ID_Flush,
    input  PC, IF_ID_Instruction, IF_ID_PC_Plus4, stall_count, flush_count
  );

  modport slave (
    input  IF_Instruction, ID_PCSrc, ID_EX_PCSrc, EX_ALUResult0, EX_BranchTarget,
           ID_JumpTarget, ID_JrTarget, PCWrite, IF_ID_WRITE, IF_ID_Flush,
    output PC, IF_ID_Instruction, IF_ID_PC_Plus4, stall_count, flush_count
  );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (inc && !(&r_count)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pc_ifid_stage.sv
// Program counter, next-PC select and IF/ID register driven by active-low hazard control vectors.
module pc_ifid_stage import pc_ifid_stage_pkg::*; #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter logic [31:0] ILLOP_ADDR = 32'h8000_0004,
  parameter logic [31:0] XADR_ADDR  = 32'h8000_0008
) (
  input  logic          clk,
  input  logic          reset,
  pc_ifid_stage_if.slave bus
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_jr_target;
  ifid_t       r_ifid;
  ifid_t       w_ifid_next;
  logic        w_br_taken;
  logic        w_pc_hold;
  logic        w_bubble;

  assign w_pc_plus4  = pc_plus4(r_pc);
  assign w_br_taken  = (bus.ID_EX_PCSrc == PCSRC_BR) && bus.EX_ALUResult0;
  assign w_pc_hold   = !w_br_taken && !(&bus.PCWrite);
  // A jr must never promote user code into kernel space.
  assign w_jr_target = (bus.ID_JrTarget & 32'h7FFF_FFFF) | {r_pc[31], 31'b0};

  always_comb begin
    w_pc_next = w_pc_plus4;
    if (w_br_taken) begin
      w_pc_next = bus.EX_BranchTarget;
    end else if (w_pc_hold) begin
      w_pc_next = r_pc;
    end else begin
      case (bus.ID_PCSrc)
        PCSRC_J:     w_pc_next = bus.ID_JumpTarget;
        PCSRC_JR:    w_pc_next = w_jr_target;
        PCSRC_ILLOP: w_pc_next = ILLOP_ADDR;
        PCSRC_XADR:  w_pc_next = XADR_ADDR;
        default:     w_pc_next = w_pc_plus4;
      endcase
    end
  end

  // The EX branch squash outranks an ID-side hold so a stalled jr cannot survive a taken branch.
  always_comb begin
    w_bubble    = 1'b0;
    w_ifid_next = '{instr: bus.IF_Instruction, pc_plus4: w_pc_plus4};
    if (!bus.IF_ID_Flush[HZ_BRANCH] || w_br_taken) begin
      w_bubble = 1'b1;
    end else if (!(&bus.IF_ID_WRITE)) begin
      w_ifid_next = r_ifid;
    end else if (!bus.IF_ID_Flush[HZ_JUMP] || !bus.IF_ID_Flush[HZ_LOADUSE]) begin
      w_bubble = 1'b1;
    end
    if (w_bubble) begin
      w_ifid_next = '{instr: NOP_INSTR, pc_plus4: w_pc_plus4};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= RESET_PC;
      r_ifid <= '{instr: NOP_INSTR, pc_plus4: pc_plus4(RESET_PC)};
    end else begin
      r_pc   <= w_pc_next;
      r_ifid <= w_ifid_next;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (w_pc_hold),
    .count(bus.stall_count)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (w_bubble),
    .count(bus.flush_count)
  );

  assign bus.PC                = r_pc;
  assign bus.IF_ID_Instruction = r_ifid.instr;
  assign bus.IF_ID_PC_Plus4    = r_ifid.pc_plus4;

endmodule

// File: tb/tb_pc_ifid_stage.sv
// Directed bench for pc_ifid_stage: sequencing, stalls, flushes, redirects, saturation, async reset.
module tb_pc_ifid_stage;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  pc_ifid_stage_if bus ();

  pc_ifid_stage dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.PCWrite         = 3'b111;
    bus.IF_ID_WRITE     = 3'b111;
    bus.IF_ID_Flush     = 3'b111;
    bus.ID_PCSrc        = 3'b000;
    bus.ID_EX_PCSrc     = 3'b000;
    bus.EX_ALUResult0   = 1'b0;
    bus.EX_BranchTarget = 32'h0;
    bus.ID_JumpTarget   = 32'h0;
    bus.ID_JrTarget     = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stage(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] p4);
    chk({tag, ".pc"}, bus.PC, pc);
    chk({tag, ".ins"}, bus.IF_ID_Instruction, ins);
    chk({tag, ".p4"}, bus.IF_ID_PC_Plus4, p4);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] st, input logic [31:0] fl);
    chk({tag, ".stall"}, 32'(bus.stall_count), st);
    chk({tag, ".flush"}, 32'(bus.flush_count), fl);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle();
    bus.IF_Instruction = 32'hDEAD_BEEF;
    #12;
    chk_stage("rst", 32'h8000_0000, 32'h0, 32'h8000_0004);
    chk_cnt("rst", 32'h0, 32'h0);
    reset = 1'b1;

    // Free-running fetch
    bus.IF_Instruction = 32'h1111_0001; step();
    chk_stage("seq1", 32'h8000_0004, 32'h1111_0001, 32'h8000_0004);
    bus.IF_Instruction = 32'h1111_0002; step();
    chk_stage("seq2", 32'h8000_0008, 32'h1111_0002, 32'h8000_0008);
    bus.IF_Instruction = 32'h1111_0003; step();
    chk_stage("seq3", 32'h8000_000C, 32'h1111_0003, 32'h8000_000C);

    // Two load-use stall cycles
    bus.PCWrite = 3'b110; bus.IF_ID_WRITE = 3'b110;
    bus.IF_Instruction = 32'h2222_0001; step(); step();
    chk_stage("stall", 32'h8000_000C, 32'h1111_0003, 32'h8000_000C);
    chk_cnt("stall", 32'd2, 32'd0);
    idle();
    bus.IF_Instruction = 32'h2222_0002; step();
    chk_stage("resume", 32'h8000_0010, 32'h2222_0002, 32'h8000_0010);

    // Jump in ID with IF/ID flush
    bus.ID_PCSrc = 3'b010; bus.ID_JumpTarget = 32'h0040_0100; bus.IF_ID_Flush = 3'b101;
    bus.IF_Instruction = 32'h3333_0001; step();
    chk_stage("jump", 32'h0040_0100, 32'h0, 32'h8000_0014);
    chk_cnt("jump", 32'd2, 32'd1);

    // Taken branch colliding with a load-use stall: branch wins
    idle();
    bus.ID_EX_PCSrc = 3'b001; bus.EX_ALUResult0 = 1'b1; bus.EX_BranchTarget = 32'h0040_0200;
    bus.PCWrite = 3'b110; bus.IF_ID_WRITE = 3'b110; bus.IF_ID_Flush = 3'b011;
    bus.IF_Instruction = 32'h4444_0001; step();
    chk_stage("br", 32'h0040_0200, 32'h0, 32'h0040_0104);
    chk_cnt("br", 32'd2, 32'd2);

    // Branch not taken
    idle();
    bus.ID_EX_PCSrc = 3'b001; bus.EX_ALUResult0 = 1'b0; bus.EX_BranchTarget = 32'h0099_0000;
    bus.IF_Instruction = 32'h4444_0002; step();
    chk_stage("brnt", 32'h0040_0204, 32'h4444_0002, 32'h0040_0204);

    idle();
    bus.ID_PCSrc = 3'b010; bus.ID_JumpTarget = 32'h0040_0000; bus.IF_ID_Flush = 3'b101;
    bus.IF_Instruction = 32'h5555_0001; step();
    chk_stage("jump2", 32'h0040_0000, 32'h0, 32'h0040_0208);

    // User-mode jr to a kernel address has its kernel bit cleared
    bus.ID_PCSrc = 3'b011; bus.ID_JrTarget = 32'h8000_1000;
    bus.IF_Instruction = 32'h5555_0002; step();
    chk_stage("jr_user", 32'h0000_1000, 32'h0, 32'h0040_0004);
    chk_cnt("jr_user", 32'd2, 32'd4);

    idle();
    bus.ID_PCSrc = 3'b100; bus.IF_Instruction = 32'h6666_0001; step();
    chk_stage("illop", 32'h8000_0004, 32'h6666_0001, 32'h0000_1004);
    bus.ID_PCSrc = 3'b101; bus.IF_Instruction = 32'h6666_0002; step();
    chk_stage("xadr", 32'h8000_0008, 32'h6666_0002, 32'h8000_0008);
    bus.ID_PCSrc = 3'b011; bus.ID_JrTarget = 32'h0000_2000;
    bus.IF_Instruction = 32'h6666_0003; step();
    chk_stage("jr_kern", 32'h8000_2000, 32'h6666_0003, 32'h8000_000C);

    // jr waiting on load-use: IF/ID must hold, not flush
    bus.PCWrite = 3'b110; bus.IF_ID_WRITE = 3'b110; bus.IF_ID_Flush = 3'b101;
    bus.ID_JrTarget = 32'h0000_3000; bus.IF_Instruction = 32'h7777_0001; step();
    chk_stage("jr_stall", 32'h8000_2000, 32'h6666_0003, 32'h8000_000C);
    chk_cnt("jr_stall", 32'd3, 32'd4);

    // PC+4 preserves bit 31 and wraps bits 30:0
    idle();
    bus.ID_EX_PCSrc = 3'b001; bus.EX_ALUResult0 = 1'b1; bus.EX_BranchTarget = 32'hFFFF_FFFC;
    bus.IF_ID_Flush = 3'b011; bus.IF_Instruction = 32'h7777_0002; step();
    chk_stage("br_hi", 32'hFFFF_FFFC, 32'h0, 32'h8000_2004);
    idle();
    bus.IF_Instruction = 32'h7777_0003; step();
    chk_stage("wrap_k", 32'h8000_0000, 32'h7777_0003, 32'h8000_0000);
    bus.ID_EX_PCSrc = 3'b001; bus.EX_ALUResult0 = 1'b1; bus.EX_BranchTarget = 32'h7FFF_FFFC;
    bus.IF_ID_Flush = 3'b011; step();
    idle();
    bus.IF_Instruction = 32'h7777_0004; step();
    chk_stage("wrap_u", 32'h0000_0000, 32'h7777_0004, 32'h0000_0000);
    chk_cnt("wrap_u", 32'd3, 32'd6);

    // Saturating stall counter
    bus.PCWrite = 3'b110; bus.IF_ID_WRITE = 3'b110;
    for (int i = 0; i < 65531; i++) step();
    chk_cnt("sat_pre", 32'h0000_FFFE, 32'd6);
    for (int i = 0; i < 10; i++) step();
    chk_cnt("sat", 32'h0000_FFFF, 32'd6);
    chk_stage("sat", 32'h0000_0000, 32'h7777_0004, 32'h0000_0000);

    // Asynchronous reset mid-stall, between clock edges
    #2 reset = 1'b0;
    #1;
    chk_stage("arst", 32'h8000_0000, 32'h0, 32'h8000_0004);
    chk_cnt("arst", 32'h0, 32'h0);
    idle();
    #2 reset = 1'b1;
    bus.IF_Instruction = 32'h8888_0001; step();
    chk_stage("post_rst", 32'h8000_0004, 32'h8888_0001, 32'h8000_0004);
    chk_cnt("post_rst", 32'h0, 32'h0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
